// File: rtl/diy_recorder_pkg.sv
// Shared types and constants for the DIY mole recorder and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package diy_recorder_pkg;

  // Recorder FSM encoding; the mole scheduler decodes the same values.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } rec_state_t;

  localparam int          INDEX_BITS      = 8;
  localparam int          ADDR_BITS       = 23;
  localparam int          ENTRY_BITS      = 24;
  localparam logic [7:0]  MAX_ITEM        = 8'd127;
  localparam logic [22:0] MIN_GAP_DEFAULT = 23'h2000;
  // Last address of the built-in song; also used by the scheduler's table.
  localparam logic [22:0] END_ADDRESS     = 23'h4FD00;

  // Music addresses are stored and compared one bit wider so that
  // last_addr + gap can never wrap.
  function automatic logic [ENTRY_BITS-1:0] widen_addr(input logic [ADDR_BITS-1:0] a);
    return {1'b0, a};
  endfunction

endpackage

// File: rtl/diy_recorder_if.sv
// Bundle between the recorder and its neighbours (pads, music player, scheduler).
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or registered values.
import diy_recorder_pkg::*;

interface diy_recorder_if;
  logic                  diy_mode;
  logic                  mark;
  logic                  finish;
  logic [ADDR_BITS-1:0]  music_address;
  logic [INDEX_BITS-1:0] lookup_index;
  logic [ENTRY_BITS-1:0] index_address;
  logic [INDEX_BITS-1:0] total_moles;
  logic                  ready_to_use;
  logic                  recording;

  // Environment side: drives controls, reads table and status.
  modport master (
    output diy_mode, mark, finish, music_address, lookup_index,
    input  index_address, total_moles, ready_to_use, recording
  );

  // Recorder side.
  modport slave (
    input  diy_mode, mark, finish, music_address, lookup_index,
    output index_address, total_moles, ready_to_use, recording
  );
endinterface

// File: rtl/diy_recorder_mole_time_ram.sv
// Mole-time table: one synchronous write port, one registered read port.
// Latency: read data valid one cycle after rd_addr; read-during-write returns old data.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module mole_time_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 24,
  parameter int IW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [IW-1:0] LAST_INDEX = IW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; indices past the table read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_addr <= LAST_INDEX) begin
      rd_data <= mem[rd_addr[AW-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/diy_recorder.sv
// DIY recorder: each accepted pad stomp stores the music address into the mole-time table.
// Latency: entry written 2 cycles after the stomp edge; table read port 1 cycle.
// Backpressure: none; stomps too close together or while not recording are dropped.
import diy_recorder_pkg::*;

module diy_recorder #(
  parameter logic [7:0]  MAX_ITEM    = diy_recorder_pkg::MAX_ITEM,
  parameter logic [22:0] MIN_GAP     = diy_recorder_pkg::MIN_GAP_DEFAULT,
  parameter logic [22:0] END_ADDRESS = diy_recorder_pkg::END_ADDRESS
) (
  input  logic           clk,
  input  logic           reset,
  diy_recorder_if.slave  bus
);

  localparam int DEPTH  = int'(MAX_ITEM) + 1;
  localparam int RAM_AW = $clog2(DEPTH);

  rec_state_t            state;
  rec_state_t            state_nx;
  logic [INDEX_BITS-1:0] count;
  logic [ADDR_BITS-1:0]  last_addr;
  logic [ENTRY_BITS-1:0] wr_data;
  logic                  mark_q;
  logic                  finish_q;
  logic                  ready_q;
  logic                  recording_q;

  logic mark_rise;
  logic finish_rise;
  logic gap_ok;
  logic accept;
  logic at_end;
  logic have_moles;
  logic table_full;

  assign mark_rise   = bus.mark & ~mark_q;
  assign finish_rise = bus.finish & ~finish_q;
  // Widened compare: last_addr + MIN_GAP may exceed 23 bits near the song end.
  assign gap_ok      = widen_addr(bus.music_address) >= (widen_addr(last_addr) + widen_addr(MIN_GAP));
  assign accept      = (count == '0) || gap_ok;
  assign at_end      = bus.music_address >= END_ADDRESS;
  assign have_moles  = (count != '0);
  assign table_full  = (count == INDEX_BITS'(MAX_ITEM));

  // Next-state selection; dropping diy_mode overrides everything else.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.diy_mode) state_nx = ST_REC;
      end
      ST_REC: begin
        // A mark wins over a simultaneous finish; the finish is dropped.
        if (mark_rise && accept) begin
          state_nx = ST_WRITE;
        end else if (at_end) begin
          state_nx = have_moles ? ST_DONE : ST_IDLE;
        end else if (finish_rise && have_moles) begin
          state_nx = ST_DONE;
        end
      end
      ST_WRITE: begin
        state_nx = table_full ? ST_DONE : ST_REC;
      end
      ST_DONE: begin
        state_nx = ST_DONE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    if (!bus.diy_mode) state_nx = ST_IDLE;
  end

  // State register, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      last_addr   <= '0;
      wr_data     <= '0;
      mark_q      <= 1'b0;
      finish_q    <= 1'b0;
      ready_q     <= 1'b0;
      recording_q <= 1'b0;
    end else begin
      mark_q      <= bus.mark;
      finish_q    <= bus.finish;
      state       <= state_nx;
      ready_q     <= (state_nx == ST_DONE);
      recording_q <= (state_nx == ST_REC) || (state_nx == ST_WRITE);
      case (state)
        ST_IDLE: begin
          count     <= '0;
          last_addr <= '0;
        end
        ST_REC: begin
          if (state_nx == ST_WRITE) wr_data <= widen_addr(bus.music_address);
        end
        ST_WRITE: begin
          // Commits even when diy_mode just dropped; IDLE clears count afterwards.
          last_addr <= wr_data[ADDR_BITS-1:0];
          count     <= count + INDEX_BITS'(1);
        end
        default: begin
        end
      endcase
    end
  end

  mole_time_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_BITS),
    .IW    (INDEX_BITS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (state == ST_WRITE),
    .wr_addr (count[RAM_AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (bus.lookup_index),
    .rd_data (bus.index_address)
  );

  assign bus.total_moles  = count;
  assign bus.ready_to_use = ready_q;
  assign bus.recording    = recording_q;

endmodule
